// File: rtl/sample_frame_buffer.sv
// Ping-pong frame buffer between the microphone sample generator and the FFT core.
// Samples are captured on sampleClock rising edges; full frames stream out over valid/ready.
module sample_frame_buffer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int FRAME_LEN    = 64,
    parameter int INDEX_BITS   = 6
) (
    input  logic                    inputClock,
    input  logic                    reset_n,
    input  logic                    sampleClock,
    input  logic [SAMPLE_WIDTH-1:0] inputSample,
    output logic                    frameOut_valid,
    input  logic                    frameOut_ready,
    output logic [SAMPLE_WIDTH-1:0] frameOut_data,
    output logic [INDEX_BITS-1:0]   frameOut_index,
    output logic                    frameOut_last,
    output logic [7:0]              framesDropped,
    output logic [INDEX_BITS:0]     fillLevel
);

    // state  | meaning
    // IDLE   | no frame pending; waiting for the writer to complete a bank
    // LOAD   | read of address 0 in flight, output not yet valid
    // STREAM | beat presented; advances on each handshake, prefetching the next address

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(FRAME_LEN - 1);

    rd_state_t               state_q, state_d;
    logic                    sc_sync1, sc_sync2, sc_prev;
    logic                    strobe, frame_done, handshake, last_beat, reader_free, swap;
    logic                    wr_bank, rd_bank;
    logic [INDEX_BITS-1:0]   wr_idx, rd_ptr, rd_addr, idx_next;
    logic                    rd_en;
    logic [SAMPLE_WIDTH-1:0] mem [2*FRAME_LEN];

    assign strobe      = sc_sync2 & ~sc_prev;
    assign frame_done  = strobe && (wr_idx == LAST_IDX);
    assign handshake   = frameOut_valid && frameOut_ready;
    assign last_beat   = handshake && frameOut_last;
    assign reader_free = (state_q == IDLE) || last_beat;
    assign swap        = frame_done && reader_free;
    assign idx_next    = frameOut_index + 1'b1;
    assign fillLevel   = {1'b0, wr_idx};

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = rd_ptr;
        case (state_q)
            IDLE: begin
                if (swap) state_d = LOAD;
            end
            LOAD: begin
                rd_en   = 1'b1;
                rd_addr = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (last_beat) begin
                    state_d = swap ? LOAD : IDLE;
                end else if (handshake) begin
                    rd_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inputClock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sc_sync1       <= 1'b0;
            sc_sync2       <= 1'b0;
            sc_prev        <= 1'b0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b1;
            wr_idx         <= '0;
            rd_ptr         <= '0;
            framesDropped  <= '0;
            frameOut_valid <= 1'b0;
            frameOut_index <= '0;
            frameOut_last  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sc_sync1       <= sampleClock;
            sc_sync2       <= sc_sync1;
            sc_prev        <= sc_sync2;
            frameOut_valid <= (state_d == STREAM);

            // writeIndex wraps to 0 on the completing strobe
            if (strobe) wr_idx <= wr_idx + 1'b1;

            if (swap) begin
                wr_bank <= ~wr_bank;
                rd_bank <= wr_bank;
            end else if (frame_done && framesDropped != 8'hFF) begin
                framesDropped <= framesDropped + 8'd1;
            end

            if (state_q == LOAD) begin
                frameOut_index <= '0;
                frameOut_last  <= 1'b0;
                rd_ptr         <= INDEX_BITS'(1);
            end else if (handshake && !frameOut_last) begin
                frameOut_index <= idx_next;
                frameOut_last  <= (idx_next == LAST_IDX);
                rd_ptr         <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge inputClock) begin
        if (strobe) mem[{wr_bank, wr_idx}] <= inputSample;
    end

    // The read register doubles as the output data register.
    always_ff @(posedge inputClock) begin
        if (!reset_n) begin
            frameOut_data <= '0;
        end else if (rd_en) begin
            frameOut_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule
